sine_phase_nco: RTL and testbench

//  Numerically controlled phase generator that feeds the quarter-wave sine ROM stage.

---
 rtl/sine_pkg.sv | 16 +
 rtl/sample_prescaler.sv | 34 +++
 rtl/sine_phase_nco.sv | 104 ++++++++++
 tb/tb_sine_phase_nco.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared definitions for the sine generator: quadrant encoding and table sizes.
// Used by the phase NCO and by the quarter-wave ROM stage.
package sine_pkg;

  // Quadrant of the sine period, taken from the top two accumulator bits.
  typedef enum logic [1:0] {
    Q_RISE     = 2'd0,
    Q_FALL     = 2'd1,
    Q_NEG_FALL = 2'd2,
    Q_NEG_RISE = 2'd3
  } quadrant_t;

  localparam int unsigned QUARTER_LEN = 128;
  localparam int unsigned SAMPLE_W    = 10;

endpackage

// File: rtl/sample_prescaler.sv
// Sample-rate prescaler: asserts tick every div+1 enabled cycles.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   enable      count only when set; holds otherwise
//   clear       synchronous restart; suppresses tick in the same cycle
//   div         live divide value; lowering it below the count ticks next enabled cycle
//   tick        combinational tick for the current cycle
module sample_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt;

  // >= rather than == so a reduced div takes effect without a full wrap
  assign tick = enable & ~clear & (div_cnt >= div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (clear || tick) begin
      div_cnt <= '0;
    end else if (enable) begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/sine_phase_nco.sv
// Programmable phase accumulator feeding the quarter-wave sine ROM stage.
// f_out = f_clk * tune_word / (2^ACC_W * (sample_div+1)).
// Ports:
//   clk, rst_n     clock, async active-low reset
//   enable         1 = run; 0 = freeze accumulator, prescaler and outputs
//   sync_clear     synchronous phase/prescaler/output clear, wins over a tick
//   sample_div     tick every sample_div+1 enabled cycles
//   tune_word      new phase increment, offered with tune_valid
//   tune_valid     tune_word offered
//   tune_ready     pending slot empty; transfer on tune_valid & tune_ready
//   quadrant       acc[ACC_W-1 -: 2]
//   quarter_addr   acc[ACC_W-3 -: ADDR_W], unmirrored
//   sample_stb     one-cycle pulse when quadrant/quarter_addr were just updated
//   cycle_wrap     one-cycle pulse with sample_stb when the accumulator carried out
module sine_phase_nco
  import sine_pkg::*;
#(
  parameter int unsigned      ACC_W    = 24,
  parameter int unsigned      ADDR_W   = 7,
  parameter int unsigned      DIV_W    = 16,
  parameter logic [ACC_W-1:0] RESET_TW = ACC_W'(1 << 15)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sync_clear,
  input  logic [DIV_W-1:0]  sample_div,
  input  logic [ACC_W-1:0]  tune_word,
  input  logic              tune_valid,
  output logic              tune_ready,
  output logic [1:0]        quadrant,
  output logic [ADDR_W-1:0] quarter_addr,
  output logic              sample_stb,
  output logic              cycle_wrap
);

  logic             tick;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] active_tw;
  logic [ACC_W-1:0] pending_tw;
  logic [ACC_W:0]   sum_c;
  logic             carry_c;
  logic             accept_c;
  logic             apply_c;

  sample_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .clear  (sync_clear),
    .div    (sample_div),
    .tick   (tick)
  );

  assign sum_c    = {1'b0, acc} + {1'b0, active_tw};
  assign carry_c  = sum_c[ACC_W];
  assign accept_c = tune_valid & tune_ready;
  // Pending word (tune_ready low) switches in only on a wrapping tick so the
  // waveform never jumps mid-period; a stopped phase never wraps, so apply at once.
  assign apply_c  = tick & ~tune_ready & (carry_c | (active_tw == '0));

  // Accumulator and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      quadrant     <= Q_RISE;
      quarter_addr <= '0;
      sample_stb   <= 1'b0;
      cycle_wrap   <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      cycle_wrap <= 1'b0;
      if (sync_clear) begin
        acc          <= '0;
        quadrant     <= Q_RISE;
        quarter_addr <= '0;
      end else if (tick) begin
        acc          <= sum_c[ACC_W-1:0];
        quadrant     <= sum_c[ACC_W-1 -: 2];
        quarter_addr <= sum_c[ACC_W-3 -: ADDR_W];
        sample_stb   <= 1'b1;
        cycle_wrap   <= carry_c;
      end
    end
  end

  // Tuning register pair; tune_ready doubles as the pending-empty flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_tw  <= RESET_TW;
      pending_tw <= '0;
      tune_ready <= 1'b1;
    end else if (accept_c) begin
      pending_tw <= tune_word;
      tune_ready <= 1'b0;
    end else if (apply_c) begin
      active_tw  <= pending_tw;
      tune_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sine_phase_nco.sv
// Self-checking bench for sine_phase_nco: directed table, corner sequences and
// randomized traffic against a behavioural phase model.
module tb_sine_phase_nco;

  localparam int unsigned ACC_W  = 24;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DIV_W  = 16;
  localparam longint      MOD    = longint'(1) << ACC_W;
  localparam longint      RST_TW = longint'(1) << 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              sync_clear;
  logic [DIV_W-1:0]  sample_div;
  logic [ACC_W-1:0]  tune_word;
  logic              tune_valid;
  logic              tune_ready;
  logic [1:0]        quadrant;
  logic [ADDR_W-1:0] quarter_addr;
  logic              sample_stb;
  logic              cycle_wrap;

  int checks   = 0;
  int failures = 0;

  sine_phase_nco dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sync_clear   (sync_clear),
    .sample_div   (sample_div),
    .tune_word    (tune_word),
    .tune_valid   (tune_valid),
    .tune_ready   (tune_ready),
    .quadrant     (quadrant),
    .quarter_addr (quarter_addr),
    .sample_stb   (sample_stb),
    .cycle_wrap   (cycle_wrap)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase as an integer modulo 2^ACC_W
  longint m_acc, m_active, m_pend_w, m_cnt;
  bit     m_pend, m_stb, m_wrap;
  int     m_quad, m_addr;

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_active = RST_TW; m_pend = 0; m_pend_w = 0;
    m_stb = 0; m_wrap = 0; m_quad = 0; m_addr = 0;
  endtask

  task automatic model_clk();
    bit     tick, carry, apply, accept;
    longint sum;
    tick   = enable && !sync_clear && (m_cnt >= longint'(sample_div));
    accept = tune_valid && !m_pend;
    sum    = m_acc + m_active;
    carry  = sum >= MOD;
    apply  = tick && m_pend && (carry || m_active == 0);
    m_stb  = 0;
    m_wrap = 0;
    if (sync_clear) begin
      m_acc = 0; m_cnt = 0; m_quad = 0; m_addr = 0;
    end else if (tick) begin
      m_acc  = sum % MOD;
      m_cnt  = 0;
      m_quad = int'(m_acc / (MOD / 4));
      m_addr = int'((m_acc / 32768) % 128);
      m_stb  = 1;
      m_wrap = carry;
    end else if (enable) begin
      m_cnt = m_cnt + 1;
    end
    if (accept) begin
      m_pend = 1; m_pend_w = longint'(tune_word);
    end else if (apply) begin
      m_active = m_pend_w; m_pend = 0;
    end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_quadrant"}, longint'(quadrant), longint'(m_quad));
    chk({tag, "_addr"}, longint'(quarter_addr), longint'(m_addr));
    chk({tag, "_stb"}, longint'(sample_stb), longint'(m_stb));
    chk({tag, "_wrap"}, longint'(cycle_wrap), longint'(m_wrap));
    chk({tag, "_ready"}, longint'(tune_ready), longint'(!m_pend));
  endtask

  // One clock: model follows the edge, outputs sampled on the falling edge
  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_clk();
    @(negedge clk);
  endtask

  typedef struct {
    bit              en;
    bit              clr;
    logic [DIV_W-1:0] div;
    bit              stb;
    int              addr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int wraps, stbs, cnt, prev_addr, n;
    bit hit;
    logic [1:0]        sv_q;
    logic [ADDR_W-1:0] sv_a;
    logic [ACC_W-1:0]  words[6];

    vecs[0]  = '{1, 0, 0, 1, 1};
    vecs[1]  = '{1, 0, 0, 1, 2};
    vecs[2]  = '{0, 0, 0, 0, 2};
    vecs[3]  = '{1, 0, 2, 0, 2};
    vecs[4]  = '{1, 0, 2, 0, 2};
    vecs[5]  = '{1, 0, 2, 1, 3};
    vecs[6]  = '{1, 0, 2, 0, 3};
    vecs[7]  = '{1, 0, 0, 1, 4};
    vecs[8]  = '{1, 1, 0, 0, 0};
    vecs[9]  = '{1, 0, 0, 1, 1};
    vecs[10] = '{0, 1, 0, 0, 0};
    vecs[11] = '{1, 0, 1, 0, 0};
    vecs[12] = '{1, 0, 1, 1, 1};

    rst_n = 0; enable = 0; sync_clear = 0; sample_div = '0;
    tune_word = '0; tune_valid = 1;
    model_reset();

    // Reset held with an offer present: slot stays empty, outputs zero
    repeat (3) step();
    chk("rst_ready", longint'(tune_ready), 1);
    chk("rst_quadrant", longint'(quadrant), 0);
    chk("rst_addr", longint'(quarter_addr), 0);
    chk("rst_stb", longint'(sample_stb), 0);
    chk("rst_wrap", longint'(cycle_wrap), 0);
    tune_valid = 0;
    rst_n = 1;

    // Directed table from reset state
    for (int i = 0; i < 13; i++) begin
      enable = vecs[i].en; sync_clear = vecs[i].clr; sample_div = vecs[i].div;
      step();
      chk($sformatf("vec%0d_stb", i), longint'(sample_stb), longint'(vecs[i].stb));
      chk($sformatf("vec%0d_addr", i), longint'(quarter_addr), longint'(vecs[i].addr));
      chk($sformatf("vec%0d_quad", i), longint'(quadrant), 0);
    end

    // Defaults, full periods at sample_div=0
    sync_clear = 1; step(); sync_clear = 0;
    enable = 1; sample_div = '0;
    wraps = 0; stbs = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      chk_model("dflt");
      if (sample_stb) stbs++;
      if (cycle_wrap) begin
        wraps++;
        chk("wrap_quadrant", longint'(quadrant), 0);
        chk("wrap_addr", longint'(quarter_addr), 0);
      end
    end
    chk("dflt_wraps", longint'(wraps), 2);
    chk("dflt_stbs", longint'(stbs), 1100);

    // sample_div=3, then drop to 0 mid-count
    sync_clear = 1; step(); sync_clear = 0;
    sample_div = 3; stbs = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk_model("div3");
      if (sample_stb) stbs++;
    end
    chk("div3_stbs", longint'(stbs), 3);
    step();
    chk("div3_midcount_stb", longint'(sample_stb), 0);
    sample_div = 0;
    step();
    chk("div_lower_tick", longint'(sample_stb), 1);
    chk_model("div_lower");

    // Retune at quarter_addr=40; takes effect only at the wrap
    hit = 0;
    for (int i = 0; i < 300 && !hit; i++) begin
      step();
      chk_model("seek40");
      if (quarter_addr == 40) hit = 1;
    end
    chk("seek40_found", longint'(hit), 1);
    tune_word = ACC_W'(1 << 16); tune_valid = 1;
    step();
    chk_model("tune_accept");
    tune_valid = 0;
    chk("tune_ready_drop", longint'(tune_ready), 0);
    prev_addr = int'(quarter_addr);
    hit = 0;
    for (int i = 0; i < 700 && !hit; i++) begin
      step();
      chk_model("tune_wait");
      if (cycle_wrap) begin
        hit = 1;
        chk("tune_ready_rise", longint'(tune_ready), 1);
      end else begin
        chk("tune_old_step", longint'((int'(quarter_addr) - prev_addr + 128) % 128), 1);
        chk("tune_ready_low", longint'(tune_ready), 0);
      end
      prev_addr = int'(quarter_addr);
    end
    chk("tune_wrap_seen", longint'(hit), 1);
    step();
    chk("tune_new_step", longint'(quarter_addr), 2);
    chk_model("tune_after");

    // Freeze for 10 cycles, then sync_clear against a tick
    sv_q = quadrant; sv_a = quarter_addr;
    enable = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("frz_stb", longint'(sample_stb), 0);
      chk("frz_addr", longint'(quarter_addr), longint'(sv_a));
      chk("frz_quad", longint'(quadrant), longint'(sv_q));
    end
    enable = 1; sync_clear = 1;
    step();
    sync_clear = 0;
    chk("clr_addr", longint'(quarter_addr), 0);
    chk("clr_quad", longint'(quadrant), 0);
    chk("clr_stb", longint'(sample_stb), 0);

    // Reset mid quadrant 2 with a pending word
    hit = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      step();
      chk_model("seekq2");
      if (quadrant == 2 && quarter_addr > 20) hit = 1;
    end
    chk("seekq2_found", longint'(hit), 1);
    tune_word = ACC_W'(3 << 15); tune_valid = 1;
    step();
    tune_valid = 0;
    chk("q2_pending", longint'(tune_ready), 0);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("arst_quad", longint'(quadrant), 0);
    chk("arst_addr", longint'(quarter_addr), 0);
    chk("arst_ready", longint'(tune_ready), 1);
    chk("arst_stb", longint'(sample_stb), 0);
    @(negedge clk);
    rst_n = 1;
    step();
    chk("arst_tw1", longint'(quarter_addr), 1);
    step();
    chk("arst_tw2", longint'(quarter_addr), 2);
    chk_model("arst_after");

    // Randomized traffic against the model
    words[0] = ACC_W'(1 << 14); words[1] = ACC_W'(1 << 15); words[2] = ACC_W'(1 << 16);
    words[3] = ACC_W'(3 << 15); words[4] = '0; words[5] = '0;
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom % 8) != 0;
      sync_clear = ($urandom % 64) == 0;
      if (($urandom % 32) == 0) sample_div = DIV_W'($urandom % 4);
      tune_valid = ($urandom % 16) == 0;
      n = int'($urandom % 7);
      tune_word = (n < 6) ? words[n] : ACC_W'($urandom_range(1 << 12, 1 << 20));
      step();
      chk_model("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
